// File: rtl/bram_debug_sequencer.sv
// bram_debug_sequencer
//   Drives the second (debug) port of N_CHAN BRAMs so that memory images can be
//   loaded, dumped and cleared in hardware. It also lets the RV32I core run
//   for a bounded number of cycles. The core is held in reset in every state
//   except RUN.
//
// Ports
//   CPU_CLK, CPU_RST        clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready     command handshake; ready only in IDLE
//   cmd_op                  00 LOAD, 01 DUMP, 10 CLEAR, 11 RUN
//   cmd_chan, cmd_base      target channel and start word index
//   cmd_len                 word count (LOAD/DUMP/CLEAR) or cycle count (RUN)
//   in_valid/in_ready/in_data      LOAD word stream
//   out_valid/out_ready/out_data   DUMP word stream
//   dbg_a2/dbg_wd2/dbg_we2  per-channel byte address, write data, byte enables
//   dbg_rd2                 per-channel read data (1-cycle synchronous read)
//   core_rst                reset to the core, low only in RUN
//   busy                    sequencer not in IDLE
//   err                     sticky command-reject flag, cleared by CPU_RST
//
// States
//   S_IDLE   | waiting for a command
//   S_LOAD   | writing one in_data word per in_valid beat
//   S_D_ADDR | presenting the dump address to the BRAM
//   S_D_WAIT | BRAM read latency cycle
//   S_D_OUT  | out_data holds the read word until out_ready
//   S_CLEAR  | writing zero, one word per cycle
//   S_RUN    | core out of reset, cycle budget counting down

module bram_debug_sequencer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int N_CHAN      = 2,
    parameter int LEN_W       = 32
) (
    input  logic                           CPU_CLK,
    input  logic                           CPU_RST,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [$clog2(N_CHAN)-1:0]      cmd_chan,
    input  logic [$clog2(DEPTH_WORDS)-1:0] cmd_base,
    input  logic [LEN_W-1:0]               cmd_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [N_CHAN*ADDR_W-1:0]       dbg_a2,
    output logic [N_CHAN*DATA_W-1:0]       dbg_wd2,
    output logic [N_CHAN*DATA_W/8-1:0]     dbg_we2,
    input  logic [N_CHAN*DATA_W-1:0]       dbg_rd2,
    output logic                           core_rst,
    output logic                           busy,
    output logic                           err
);
    localparam int NB     = DATA_W / 8;
    localparam int CHAN_W = $clog2(N_CHAN);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int SUM_W  = LEN_W + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_DUMP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_D_ADDR, S_D_WAIT, S_D_OUT, S_CLEAR, S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              err_q, err_d;

    logic [SUM_W-1:0]  end_sum;
    logic              cmd_bad;
    logic              last;
    logic [DATA_W-1:0] rd_sel;
    logic              mem_active;
    logic              write_en;
    logic [DATA_W-1:0] write_data;

    // One extra bit so base+len cannot wrap past the depth check.
    assign end_sum = {1'b0, cmd_len} + SUM_W'(cmd_base);
    assign cmd_bad = (cmd_len == '0) ||
                     ((cmd_op != 2'b11) &&
                      ((int'(cmd_chan) >= N_CHAN) || (end_sum > SUM_W'(DEPTH_WORDS))));
    // cnt_q is the number of words/cycles still to go, including the current one.
    assign last    = (cnt_q == LEN_W'(1));
    assign rd_sel  = dbg_rd2[int'(chan_q)*DATA_W +: DATA_W];

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state_q    <= S_IDLE;
            chan_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        chan_d = cmd_chan;
                        idx_d  = cmd_base;
                        cnt_d  = cmd_len;
                        case (cmd_op)
                            OP_LOAD:  state_d = S_LOAD;
                            OP_DUMP:  state_d = S_D_ADDR;
                            OP_CLEAR: state_d = S_CLEAR;
                            default:  state_d = S_RUN;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (last) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                if (last) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            S_D_ADDR: state_d = S_D_WAIT;
            S_D_WAIT: begin
                out_data_d = rd_sel;
                state_d    = S_D_OUT;
            end
            S_D_OUT: begin
                if (out_ready) begin
                    if (last) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = S_D_ADDR;
                    end
                end
            end
            S_RUN: begin
                if (last) state_d = S_IDLE;
                else      cnt_d   = cnt_q - LEN_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_D_OUT);
    assign core_rst  = (state_q != S_RUN);
    assign out_data  = out_data_q;
    assign err       = err_q;

    assign mem_active = (state_q == S_LOAD) || (state_q == S_CLEAR) ||
                        (state_q == S_D_ADDR) || (state_q == S_D_WAIT) ||
                        (state_q == S_D_OUT);
    assign write_en   = ((state_q == S_LOAD) && in_valid) || (state_q == S_CLEAR);
    assign write_data = (state_q == S_LOAD) ? in_data : '0;

    // Only the selected channel sees any activity; the rest stay at zero.
    always_comb begin
        dbg_a2  = '0;
        dbg_wd2 = '0;
        dbg_we2 = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (mem_active && (int'(chan_q) == c)) begin
                dbg_a2[c*ADDR_W +: ADDR_W]  = ADDR_W'(idx_q) * ADDR_W'(NB);
                dbg_wd2[c*DATA_W +: DATA_W] = write_data;
                dbg_we2[c*NB +: NB]         = {NB{write_en}};
            end
        end
    end

endmodule

// File: tb/tb_bram_debug_sequencer.sv
module tb_bram_debug_sequencer;
    localparam int DEPTH  = 4096;
    localparam int N_CHAN = 2;
    localparam int NB     = 4;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [0:0]  cmd_chan;
    logic [11:0] cmd_base;
    logic [31:0] cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [63:0] dbg_a2;
    logic [63:0] dbg_wd2;
    logic [7:0]  dbg_we2;
    logic [63:0] dbg_rd2;
    logic        core_rst;
    logic        busy;
    logic        err;

    logic [31:0] bram    [N_CHAN][DEPTH];
    logic [31:0] exp_mem [N_CHAN][DEPTH];
    logic [31:0] dq[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    bram_debug_sequencer dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_chan(cmd_chan), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dbg_a2(dbg_a2), .dbg_wd2(dbg_wd2), .dbg_we2(dbg_we2), .dbg_rd2(dbg_rd2),
        .core_rst(core_rst), .busy(busy), .err(err)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    // BRAM port 2: byte-enable write, 1-cycle synchronous read.
    always @(posedge CPU_CLK) begin
        for (int c = 0; c < N_CHAN; c++) begin
            for (int b = 0; b < NB; b++)
                if (dbg_we2[c*NB+b])
                    bram[c][dbg_a2[c*32+2 +: 12]][b*8 +: 8] <= dbg_wd2[c*32+b*8 +: 8];
            dbg_rd2[c*32 +: 32] <= bram[c][dbg_a2[c*32+2 +: 12]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_we2"}, dbg_we2, 0);
        chk({tag, "_a2"}, dbg_a2, 0);
        chk({tag, "_wd2"}, dbg_wd2, 0);
    endtask

    task automatic pulse_reset();
        CPU_RST = 1'b1;
        #1;
        check_reset("rst_pulse");
        tick();
        CPU_RST = 1'b0;
        tick();
    endtask

    task automatic send_cmd(input logic [1:0] op, input int ch, input int base,
                            input logic [31:0] len);
        chk("cmd_ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_chan  = 1'(ch);
        cmd_base  = 12'(base);
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic fill_rand(input int n);
        dq = {};
        for (int k = 0; k < n; k++) dq.push_back($urandom);
    endtask

    // mode 0: in_valid always high, 1: every other cycle, 2: random
    task automatic do_load(input int ch, input int base, input int mode);
        int i = 0;
        int cyc = 0;
        logic v;
        send_cmd(2'b00, ch, base, 32'(dq.size()));
        while (i < dq.size() && cyc < 1000) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = cyc[0];
            else                v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = dq[i];
            #1;
            chk("load_in_ready", in_ready, 1);
            if (v) begin
                chk("load_we2", dbg_we2, 64'(8'h0F) << (ch*4));
                chk("load_a2", dbg_a2[ch*32 +: 32], (base+i)*4);
                chk("load_wd2", dbg_wd2[ch*32 +: 32], dq[i]);
                exp_mem[ch][base+i] = dq[i];
            end else begin
                chk("load_idle_we2", dbg_we2, 0);
            end
            tick();
            if (v) i++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("load_beats", i, dq.size());
        chk("load_done_ready", cmd_ready, 1);
    endtask

    // mode 0: out_ready always high, 1: random, 2: hold word 1 for 5 cycles
    task automatic do_dump(input int ch, input int base, input int len, input int mode);
        int i = 0;
        int cyc = 0;
        int stall = 0;
        logic r;
        send_cmd(2'b01, ch, base, 32'(len));
        while (i < len && cyc < 2000) begin
            if (out_valid) begin
                chk("dump_data", out_data, exp_mem[ch][base+i]);
                if (mode == 0)      r = 1'b1;
                else if (mode == 1) r = 1'($urandom_range(0, 1));
                else                r = !(i == 1 && stall < 5);
                if (!r) stall++;
                out_ready = r;
                if (r) i++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            chk("dump_no_write", dbg_we2, 0);
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("dump_words", i, len);
        chk("dump_done_ready", cmd_ready, 1);
        if (mode == 0) chk("dump_cycles", cyc, 3*len);
        if (mode == 2) chk("dump_stall_cycles", stall, 5);
    endtask

    task automatic do_clear(input int ch, input int base, input int len);
        int bad = 0;
        send_cmd(2'b10, ch, base, 32'(len));
        for (int k = 0; k < len; k++) begin
            if (dbg_we2 !== (8'h0F << (ch*4)) || dbg_a2[ch*32 +: 32] !== 32'((base+k)*4)
                || dbg_wd2[ch*32 +: 32] !== 32'h0)
                bad++;
            exp_mem[ch][base+k] = 32'h0;
            tick();
        end
        chk("clear_bad_cycles", bad, 0);
        chk("clear_done_ready", cmd_ready, 1);
    endtask

    task automatic do_run(input int len);
        int n = 0;
        int bad = 0;
        send_cmd(2'b11, $urandom_range(0, 1), $urandom_range(0, DEPTH-1), 32'(len));
        while (core_rst == 1'b0 && n < len + 20) begin
            if (!busy || cmd_ready) bad++;
            n++;
            tick();
        end
        chk("run_low_cycles", n, len);
        chk("run_busy", bad, 0);
        chk("run_idle_after", busy, 0);
        chk("run_core_rst_after", core_rst, 1);
    endtask

    task automatic reject_cmd(input string tag, input logic [1:0] op, input int ch,
                              input int base, input logic [31:0] len);
        send_cmd(op, ch, base, len);
        chk({tag, "_err"}, err, 1);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        in_valid = 1'b1;
        #1;
        chk({tag, "_we2"}, dbg_we2, 0);
        tick();
        in_valid = 1'b0;
        chk({tag, "_still_idle"}, busy, 0);
    endtask

    initial begin
        int ch, len, base;
        CPU_RST   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_chan  = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int c = 0; c < N_CHAN; c++)
            for (int w = 0; w < DEPTH; w++) exp_mem[c][w] = 32'h0;

        repeat (3) tick();
        check_reset("reset");
        CPU_RST = 1'b0;
        tick();

        do_clear(0, 0, DEPTH);
        do_clear(1, 0, DEPTH);

        dq = {32'h11, 32'h22, 32'h33, 32'h44};
        do_load(0, 0, 0);
        do_dump(0, 0, 4, 0);

        fill_rand(9);
        do_load(1, 100, 1);
        do_dump(1, 100, 9, 1);
        do_dump(1, 100, 9, 2);

        fill_rand(8);
        do_load(0, DEPTH-8, 2);
        chk("boundary_err", err, 0);
        do_dump(0, DEPTH-8, 8, 0);

        reject_cmd("rej_depth", 2'b00, 0, DEPTH-6, 32'd8);
        do_dump(0, DEPTH-8, 8, 0);
        pulse_reset();
        reject_cmd("rej_len0", 2'b01, 1, 0, 32'd0);
        pulse_reset();
        reject_cmd("rej_wrap", 2'b10, 0, DEPTH-1, 32'hFFFF_FFFF);
        pulse_reset();

        do_run(100);
        do_run(1);
        do_run($urandom_range(2, 40));
        chk("run_err", err, 0);

        for (int r = 0; r < 6; r++) begin
            ch   = $urandom_range(0, 1);
            len  = $urandom_range(1, 16);
            base = $urandom_range(0, DEPTH - len);
            fill_rand(len);
            do_load(ch, base, 2);
            do_dump(ch, base, len, 1);
        end
        ch   = $urandom_range(0, 1);
        base = $urandom_range(0, DEPTH - 40);
        fill_rand(30);
        do_load(ch, base, 0);
        do_clear(ch, base + 5, 10);
        do_dump(ch, base, 30, 1);

        fill_rand(6);
        do_load(0, 8, 0);
        send_cmd(2'b10, 0, 0, 32'(DEPTH));
        repeat (10) tick();
        chk("clr_mid_a2", dbg_a2[31:0], 40);
        chk("clr_mid_we2", dbg_we2, 8'h0F);
        CPU_RST = 1'b1;
        #1;
        check_reset("async_rst");
        for (int w = 0; w < 10; w++) exp_mem[0][w] = 32'h0;
        tick();
        CPU_RST = 1'b0;
        tick();
        do_dump(0, 0, 14, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
